// File: rtl/clock_manager_pkg.sv
// Shared types and helpers for the PLL clock-domain manager.
package clock_manager_pkg;

    localparam int unsigned CM_MAX_DIV_BITS = 1024;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_HOLD,
        ST_RUN
    } cm_state_t;

    // Pulls channel ch's divisor out of the packed DIVISORS parameter.
    function automatic logic [31:0] channel_div(input logic [CM_MAX_DIV_BITS-1:0] divs,
                                                input int unsigned ch,
                                                input int unsigned w);
        logic [CM_MAX_DIV_BITS-1:0] sh;
        logic [31:0]                res;
        sh  = divs >> (ch * w);
        res = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < w) res[b] = sh[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: counts 0..DIV-1 while run is high, strobes on DIV-1.
module ce_divider #(
    parameter int                   DIV_WIDTH = 16,
    parameter logic [DIV_WIDTH-1:0] DIV       = 1
) (
    input  logic clock_in,
    input  logic reset,
    input  logic run,
    output logic ce
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV - DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 run_q;
    logic                 ce_q, ce_d;

    // run is the manager's next-state view, so cnt_q/ce_q line up with the RUN cycle itself.
    always_comb begin
        cnt_d = '0;
        if (run && run_q && (cnt_q != LAST)) cnt_d = cnt_q + DIV_WIDTH'(1);
        ce_d = run && (DIV != '0) && (cnt_d == LAST);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/clock_manager.sv
// PLL lock qualification, synchronised system reset release and phase-aligned clock enables.
module clock_manager
    import clock_manager_pkg::*;
#(
    parameter int                          NUM_CH      = 2,
    parameter int                          DIV_WIDTH   = 16,
    parameter logic [NUM_CH*DIV_WIDTH-1:0] DIVISORS    = {16'd3, 16'd1},
    parameter int                          LOCK_STABLE = 1024,
    parameter int                          RESET_HOLD  = 16,
    parameter int                          SYNC_STAGES = 2
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              locked,
    input  logic              clear_lost,
    output logic              sys_reset,
    output logic              ready,
    output logic [NUM_CH-1:0] ce,
    output logic              lock_lost
);

    localparam int CNT_MAX = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   locked_sync;
    cm_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   run_d;

    assign sync_d      = {sync_q[SYNC_STAGES-2:0], locked};
    assign locked_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_sync) state_d = ST_STABILIZE;
            end
            ST_STABILIZE: begin
                if (!locked_sync)            state_d = ST_WAIT_LOCK;
                else if (cnt_q == STAB_LAST) state_d = ST_HOLD;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_HOLD: begin
                if (!locked_sync)            state_d = ST_WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                if (!locked_sync) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
        if (state_d != state_q) cnt_d = '0;

        run_d       = (state_d == ST_RUN);
        sys_reset_d = !run_d;
        ready_d     = run_d;

        // Set has priority over a coincident clear.
        lock_lost_d = lock_lost_q;
        if (state_q == ST_RUN && state_d == ST_WAIT_LOCK) lock_lost_d = 1'b1;
        else if (clear_lost)                              lock_lost_d = 1'b0;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [DIV_WIDTH-1:0] DIV_I =
            DIV_WIDTH'(channel_div(CM_MAX_DIV_BITS'(DIVISORS), i, DIV_WIDTH));
        ce_divider #(
            .DIV_WIDTH (DIV_WIDTH),
            .DIV       (DIV_I)
        ) u_div (
            .clock_in (clock_in),
            .reset    (reset),
            .run      (run_d),
            .ce       (ce[i])
        );
    end

    assign sys_reset = sys_reset_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_clock_manager.sv
// Randomised bench for clock_manager: a lock-streak reference model feeds a scoreboard queue.
module tb_clock_manager;

    localparam int LS = 8;
    localparam int RH = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst, locked, clr;
    logic       sr_a, rdy_a, lost_a, sr_b, rdy_b, lost_b;
    logic [1:0] ce_a, ce_b;

    always #5 clk = ~clk;

    clock_manager #(.NUM_CH(2), .DIV_WIDTH(16), .DIVISORS({16'd3, 16'd1}),
                    .LOCK_STABLE(LS), .RESET_HOLD(RH), .SYNC_STAGES(SS)) dut_a (
        .clock_in(clk), .reset(rst), .locked(locked), .clear_lost(clr),
        .sys_reset(sr_a), .ready(rdy_a), .ce(ce_a), .lock_lost(lost_a));

    clock_manager #(.NUM_CH(2), .DIV_WIDTH(16), .DIVISORS({16'd0, 16'd5}),
                    .LOCK_STABLE(LS), .RESET_HOLD(RH), .SYNC_STAGES(SS)) dut_b (
        .clock_in(clk), .reset(rst), .locked(locked), .clear_lost(clr),
        .sys_reset(sr_b), .ready(rdy_b), .ce(ce_b), .lock_lost(lost_b));

    typedef struct {
        logic       sr;
        logic       rdy;
        logic       lost;
        logic [1:0] ce_a;
        logic [1:0] ce_b;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the state is a pure function of how many consecutive cycles locked_sync
    // has been high. Streak s (counted up to the previous cycle): 0 wait, 1..LS stabilise,
    // LS+1..LS+RH hold, beyond that RUN cycle n = s-LS-RH.
    int   s_m;
    logic ls_m, lost_m;
    logic hist[$];

    function automatic logic ce_bit(input int s, input int d);
        int n;
        n = s - (LS + RH);
        return (n >= 1) && (d > 0) && ((n % d) == 0);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        logic was_run;
        int   s_new;
        if (rst) begin
            s_m = 0; ls_m = 1'b0; lost_m = 1'b0;
            hist.delete();
            for (int i = 0; i < SS; i++) hist.push_back(1'b0);
        end else begin
            was_run = (s_m > LS + RH);
            s_new   = ls_m ? s_m + 1 : 0;
            if (was_run && s_new == 0) lost_m = 1'b1;
            else if (clr)              lost_m = 1'b0;
            s_m = s_new;
            hist.push_front(locked);
            void'(hist.pop_back());
            ls_m = hist[SS-1];
        end
        e.rdy  = (s_m > LS + RH);
        e.sr   = !e.rdy;
        e.lost = lost_m;
        e.ce_a = {ce_bit(s_m, 3), ce_bit(s_m, 1)};
        e.ce_b = {ce_bit(s_m, 0), ce_bit(s_m, 5)};
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rst) begin
                e.sr = 1'b1; e.rdy = 1'b0; e.lost = 1'b0; e.ce_a = '0; e.ce_b = '0;
            end
            chk("sys_reset_a", 8'(sr_a),   8'(e.sr));
            chk("ready_a",     8'(rdy_a),  8'(e.rdy));
            chk("lock_lost_a", 8'(lost_a), 8'(e.lost));
            chk("ce_a",        8'(ce_a),   8'(e.ce_a));
            chk("sys_reset_b", 8'(sr_b),   8'(e.sr));
            chk("ready_b",     8'(rdy_b),  8'(e.rdy));
            chk("lock_lost_b", 8'(lost_b), 8'(e.lost));
            chk("ce_b",        8'(ce_b),   8'(e.ce_b));
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sys_reset"}, 8'({sr_a, sr_b}),     8'b11);
        chk({tag, "_ready"},     8'({rdy_a, rdy_b}),   8'b00);
        chk({tag, "_lock_lost"}, 8'({lost_a, lost_b}), 8'b00);
        chk({tag, "_ce"},        8'({ce_a, ce_b}),     8'h0);
    endtask

    initial begin
        rst = 1'b1; locked = 1'b0; clr = 1'b0;
        cycles(3);
        check_reset_values("por");
        // Power-on with lock already present.
        rst = 1'b0; locked = 1'b1;
        cycles(30);
        // Lock loss in RUN, then a 3-cycle drop partway through stabilisation.
        locked = 1'b0; cycles(5);
        locked = 1'b1; cycles(5);
        locked = 1'b0; cycles(3);
        locked = 1'b1; cycles(30);
        // Lone clear.
        clr = 1'b1; cycles(1); clr = 1'b0; cycles(3);
        // Clear landing on the same edge as the RUN exit.
        locked = 1'b0; cycles(2);
        clr = 1'b1; cycles(1); clr = 1'b0;
        cycles(4);
        locked = 1'b1; cycles(25);
        // Asynchronous reset in the middle of HOLD.
        locked = 1'b0; cycles(4);
        locked = 1'b1; cycles(12);
        rst = 1'b1;
        #1;
        check_reset_values("async");
        cycles(2);
        rst = 1'b0;
        cycles(30);
        // Random lock behaviour with sporadic clears.
        for (int seg = 0; seg < 40; seg++) begin
            int len;
            locked = (($urandom % 3) != 0);
            len    = (($urandom % 4) == 0) ? 1 : int'($urandom_range(2, 25));
            for (int c = 0; c < len; c++) begin
                clr = (($urandom % 8) == 0);
                cycles(1);
            end
            clr = 1'b0;
        end
        locked = 1'b1;
        cycles(30);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
